reg10_parity_arbiter: RTL and testbench

Two-requester round-robin arbiter and load sequencer for the shared 10-bit parity-word register. Each requester offers a 9-bit data word; the block appends a parity bit, drives the 10-bit word to the free-running register, and verifies the register's output before granting. A sticky error flag and a saturating error count are raised when the readback mismatches. It sits between the requesting datapath blocks and the register instance, which samples its input on every rising clock edge and has no enable or clear.

---
 rtl/reg10_parity_arbiter.sv | 132 +++++++++++++
 tb/tb_reg10_parity_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg10_parity_arbiter.sv
// -----------------------------------------------------------------------------
// reg10_parity_arbiter
//
// Two-requester round-robin arbiter and load sequencer for a shared,
// free-running 10-bit parity-word register. The winning requester's 9-bit word
// gets a parity bit appended and is driven to the register. After the register
// has sampled it, the readback is verified and the owner is granted. A readback
// mismatch raises a sticky error flag and a saturating error count. The grant
// is issued whether or not the readback check passes.
//
// Parameters
//   ODD_PARITY  0: reg_d has an even ones-count, 1: reg_d has an odd ones-count
//
// Ports
//   clk      in   1   system clock, rising-edge active
//   clr_n    in   1   asynchronous active-low reset
//   req0     in   1   requester 0 write request, held until gnt0
//   data0    in   9   requester 0 data, stable while req0 is high
//   req1     in   1   requester 1 write request, held until gnt1
//   data1    in   9   requester 1 data, stable while req1 is high
//   reg_q    in  10   register output (readback)
//   reg_d    out 10   word driven to the register input, {parity, data}
//   gnt0     out  1   one-cycle pulse: requester 0 write completed
//   gnt1     out  1   one-cycle pulse: requester 1 write completed
//   busy     out  1   a transfer is in flight (LOAD or CHECK)
//   owner    out  1   index of the requester whose word is in reg_d
//   perr     out  1   sticky readback error flag
//   err_cnt  out  4   readback error count, saturates at 15
// -----------------------------------------------------------------------------
module reg10_parity_arbiter #(
    parameter logic ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       req0,
    input  logic [8:0] data0,
    input  logic       req1,
    input  logic [8:0] data1,
    input  logic [9:0] reg_q,
    output logic [9:0] reg_d,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       owner,
    output logic       perr,
    output logic [3:0] err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic [1:0] state;
    logic       last;        // requester served most recently

    logic       elig0;
    logic       elig1;
    logic       winner;
    logic [8:0] win_data;
    logic       win_par;
    logic       check_fail;

    // NOTE: every signal assigned in always_comb is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        // A requester is ignored in the cycle its own grant is high; its req
        // is still up from the transfer that just completed.
        elig0    = req0 & ~gnt0;
        elig1    = req1 & ~gnt1;
        // On a tie the requester that was not served last wins.
        winner   = (elig0 & elig1) ? ~last : elig1;
        win_data = winner ? data1 : data0;
        // Even parity: p = ^data; odd parity flips it.
        win_par  = (^win_data) ^ ODD_PARITY;
        // The register must hold exactly what was driven, and the stored word
        // must itself carry the configured parity.
        check_fail = (reg_q != reg_d) || ((^reg_q) != ODD_PARITY);
    end

    assign busy = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= ST_IDLE;
            last    <= 1'b1;     // requester 0 wins the first tie
            reg_d   <= 10'h000;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            perr    <= 1'b0;
            err_cnt <= 4'd0;
        end else begin
            // Grants are single-cycle pulses.
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (elig0 | elig1) begin
                        reg_d <= {win_par, win_data};
                        owner <= winner;
                        last  <= winner;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // The register captures reg_d on this edge.
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (owner) begin
                        gnt1 <= 1'b1;
                    end else begin
                        gnt0 <= 1'b1;
                    end
                    if (check_fail) begin
                        perr <= 1'b1;
                        if (err_cnt != 4'hF) begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg10_parity_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg10_parity_arbiter
//
// Drives two arbiter instances (even and odd parity) from the same requesters.
// Each instance has its own model of the external register, whose readback can
// be forced to zero. A transaction-level reference model predicts every output
// and is compared against both instances on each falling clock edge. Directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_reg10_parity_arbiter;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       req0, req1;
    logic [8:0] data0, data1;
    logic       fault;

    logic [9:0] reg_s   [2];
    logic [9:0] reg_q_i [2];
    logic [9:0] reg_d_o [2];
    logic       gnt0_o  [2];
    logic       gnt1_o  [2];
    logic       busy_o  [2];
    logic       owner_o [2];
    logic       perr_o  [2];
    logic [3:0] cnt_o   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg10_parity_arbiter #(.ODD_PARITY(1'b0)) u_even (
        .clk(clk), .clr_n(clr_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .reg_q(reg_q_i[0]), .reg_d(reg_d_o[0]),
        .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .busy(busy_o[0]),
        .owner(owner_o[0]), .perr(perr_o[0]), .err_cnt(cnt_o[0])
    );

    reg10_parity_arbiter #(.ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .clr_n(clr_n),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .reg_q(reg_q_i[1]), .reg_d(reg_d_o[1]),
        .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .busy(busy_o[1]),
        .owner(owner_o[1]), .perr(perr_o[1]), .err_cnt(cnt_o[1])
    );

    // External free-running register: no enable, no clear.
    always @(posedge clk) begin
        reg_s[0] <= reg_d_o[0];
        reg_s[1] <= reg_d_o[1];
    end
    assign reg_q_i[0] = fault ? 10'h000 : reg_s[0];
    assign reg_q_i[1] = fault ? 10'h000 : reg_s[1];

    // ---------------------------------------------------------------- model
    // A transfer is described by how many edges have passed since its word
    // was captured: 0 = no transfer, 1 = word driven, 2 = word in register.
    int         m_age;
    logic       m_owner, m_last;
    logic       m_gnt   [2];
    logic [9:0] m_regd  [2];
    logic       m_perr  [2];
    int         m_cnt   [2];
    logic       m_want0, m_want1, m_pick;
    logic [9:0] m_rq;

    function automatic logic [9:0] parity_word(input logic odd, input logic [8:0] d);
        int ones;
        logic p;
        ones = $countones(d);
        // Choose p so the 10-bit word's ones-count has the required parity.
        p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return {p, d};
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_age = 0; m_owner = 1'b0; m_last = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_gnt[k] = 1'b0; m_regd[k] = 10'h000; m_perr[k] = 1'b0; m_cnt[k] = 0;
            end
        end else begin
            m_want0 = req0 && !m_gnt[0];
            m_want1 = req1 && !m_gnt[1];
            m_gnt[0] = 1'b0;
            m_gnt[1] = 1'b0;
            if (m_age == 0) begin
                if (m_want0 || m_want1) begin
                    m_pick  = (m_want0 && m_want1) ? !m_last : m_want1;
                    m_owner = m_pick;
                    m_last  = m_pick;
                    for (int k = 0; k < 2; k++)
                        m_regd[k] = parity_word(k[0], m_pick ? data1 : data0);
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_rq = fault ? 10'h000 : m_regd[k];
                    if (m_rq != m_regd[k] || ($countones(m_rq) % 2) != k) begin
                        m_perr[k] = 1'b1;
                        if (m_cnt[k] < 15) m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                m_gnt[m_owner] = 1'b1;
                m_age = 0;
            end
        end
    end

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc reg_d[%0d]", k),   32'(reg_d_o[k]), 32'(m_regd[k]));
            check($sformatf("cyc gnt0[%0d]", k),    32'(gnt0_o[k]),  32'(m_gnt[0]));
            check($sformatf("cyc gnt1[%0d]", k),    32'(gnt1_o[k]),  32'(m_gnt[1]));
            check($sformatf("cyc busy[%0d]", k),    32'(busy_o[k]),  32'(m_age != 0));
            check($sformatf("cyc owner[%0d]", k),   32'(owner_o[k]), 32'(m_owner));
            check($sformatf("cyc perr[%0d]", k),    32'(perr_o[k]),  32'(m_perr[k]));
            check($sformatf("cyc err_cnt[%0d]", k), 32'(cnt_o[k]),   32'(m_cnt[k]));
            check($sformatf("cyc gnt_excl[%0d]", k), 32'(gnt0_o[k] & gnt1_o[k]), 32'd0);
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        clr_n = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        clr_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 9'h000; data1 = 9'h000; fault = 1'b0;
        tick();
        tick();
        check("rst reg_d", 32'(reg_d_o[0]), 32'h000);
        check("rst busy",  32'(busy_o[0]),  32'd0);
        check("rst owner", 32'(owner_o[0]), 32'd0);
        check("rst perr",  32'(perr_o[0]),  32'd0);
        check("rst err_cnt", 32'(cnt_o[0]), 32'd0);
        clr_n = 1'b1;
        tick();

        // Single request, even parity.
        req0 = 1'b1; data0 = 9'h1A5;
        tick();
        check("single reg_d e1", 32'(reg_d_o[0]), 32'h3A5);
        check("single busy e1",  32'(busy_o[0]),  32'd1);
        tick();
        check("single reg_q e2", 32'(reg_q_i[0]), 32'h3A5);
        check("single busy e2",  32'(busy_o[0]),  32'd1);
        check("single gnt0 e2",  32'(gnt0_o[0]),  32'd0);
        tick();
        check("single gnt0 e3",  32'(gnt0_o[0]),  32'd1);
        check("single busy e3",  32'(busy_o[0]),  32'd0);
        check("single perr",     32'(perr_o[0]),  32'd0);
        req0 = 1'b0;
        tick();
        check("single gnt0 e4",  32'(gnt0_o[0]),  32'd0);

        // Idle hold.
        repeat (20) tick();
        check("idle reg_d", 32'(reg_d_o[0]), 32'h3A5);
        check("idle busy",  32'(busy_o[0]),  32'd0);

        // Tie and fairness from a fresh reset.
        reset_pulse();
        data0 = 9'h001; data1 = 9'h003; req0 = 1'b1; req1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) begin
                check("tie reg_d e1", 32'(reg_d_o[0]), 32'h201);
                check("tie owner e1", 32'(owner_o[0]), 32'd0);
            end
            if (i == 3) check("tie gnt0 e3", 32'(gnt0_o[0]), 32'd1);
            if (i == 4) begin
                check("tie reg_d e4", 32'(reg_d_o[0]), 32'h003);
                check("tie owner e4", 32'(owner_o[0]), 32'd1);
                check("tie gnt0 e4",  32'(gnt0_o[0]),  32'd0);
            end
            if (i == 6) check("tie gnt1 e6", 32'(gnt1_o[0]), 32'd1);
            if (i == 7) check("tie reg_d e7", 32'(reg_d_o[0]), 32'h201);
            if (i == 9) begin
                check("tie gnt0 e9", 32'(gnt0_o[0]), 32'd1);
                req0 = 1'b0;
            end
            if (i == 12) begin
                check("tie gnt1 e12", 32'(gnt1_o[0]), 32'd1);
                req1 = 1'b0;
            end
        end

        // Odd-parity words on requester 1.
        tick();
        req1 = 1'b1; data1 = 9'h000;
        tick();
        check("odd reg_d 000", 32'(reg_d_o[1]), 32'h200);
        check("even reg_d 000", 32'(reg_d_o[0]), 32'h000);
        tick();
        tick();
        check("odd gnt1 a", 32'(gnt1_o[1]), 32'd1);
        req1 = 1'b0;
        tick();
        req1 = 1'b1; data1 = 9'h1FF;
        tick();
        check("odd reg_d 1FF",  32'(reg_d_o[1]), 32'h1FF);
        check("even reg_d 1FF", 32'(reg_d_o[0]), 32'h3FF);
        tick();
        tick();
        check("odd gnt1 b", 32'(gnt1_o[1]), 32'd1);
        check("odd perr",   32'(perr_o[1]), 32'd0);
        req1 = 1'b0;
        tick();

        // Readback fault: register output forced to zero.
        req0 = 1'b1; data0 = 9'h001; fault = 1'b1;
        tick();
        tick();
        tick();
        check("fault gnt0",    32'(gnt0_o[0]), 32'd1);
        check("fault perr",    32'(perr_o[0]), 32'd1);
        check("fault err_cnt", 32'(cnt_o[0]),  32'd1);
        got = 0;
        for (int c = 0; c < 120 && got < 16; c++) begin
            tick();
            if (gnt0_o[0]) got++;
        end
        check("fault grants", 32'(got), 32'd16);
        req0 = 1'b0; fault = 1'b0;
        check("fault sat even", 32'(cnt_o[0]), 32'd15);
        check("fault sat odd",  32'(cnt_o[1]), 32'd15);
        tick();

        // Reset while a transfer is in LOAD.
        req0 = 1'b1; data0 = 9'h0AA;
        tick();
        check("mid busy pre", 32'(busy_o[0]), 32'd1);
        clr_n = 1'b0;
        #1;
        check("mid reg_d",   32'(reg_d_o[0]), 32'h000);
        check("mid busy",    32'(busy_o[0]),  32'd0);
        check("mid gnt0",    32'(gnt0_o[0]),  32'd0);
        check("mid perr",    32'(perr_o[0]),  32'd0);
        check("mid err_cnt", 32'(cnt_o[0]),   32'd0);
        tick();
        tick();
        check("mid gnt0 held", 32'(gnt0_o[0]), 32'd0);
        clr_n = 1'b1;
        tick();
        check("mid reg_d e1", 32'(reg_d_o[0]), 32'h0AA);
        tick();
        check("mid gnt0 e2",  32'(gnt0_o[0]),  32'd0);
        tick();
        check("mid gnt0 e3",  32'(gnt0_o[0]),  32'd1);
        req0 = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
